// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus holding-register bank.
//   REG_W       : width of one holding register
//   wr_status_e : write result codes reported on reg_w_status
package modbus_pkg;

  localparam int REG_W = 16;

  typedef enum logic [1:0] {
    WST_OK       = 2'b00,
    WST_ILL_ADDR = 2'b01,
    WST_RO       = 2'b10,
    WST_CONFLICT = 2'b11
  } wr_status_e;

endpackage

// File: rtl/modbus_update_stretch.sv
// Per-register update flag stretcher.
// A load pulse raises flag on the next edge and holds it for exactly
// INTR_CLOCK cycles. A load during the stretch restarts the count, so the
// flag extends without a gap.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   load : successful Modbus write to this register
//   flag : stretched update flag
module modbus_update_stretch #(
  parameter int INTR_CLOCK = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic flag
);

  localparam int CNT_W = $clog2(INTR_CLOCK + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(INTR_CLOCK - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (load) begin
      cnt  <= RELOAD;
      flag <= 1'b1;
    end else if (cnt != '0) begin
      // Saturating countdown: the flag stays high while cnt is non-zero.
      cnt <= cnt - 1'b1;
    end else begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/modbus_holding_reg_bank.sv
// Bank of REG_NUM Modbus holding registers between the function handler and
// user logic.
//   clk, rst                    : clock, synchronous active-high reset
//   reg_wen/waddr/wdat          : handler write strobe, Modbus address, data
//   reg_w_done/reg_w_status     : write result pulse and status code
//   rd_en/rd_addr               : handler read strobe and Modbus address
//   rd_data/rd_vld/rd_err       : read result (data held until next rd_en)
//   host_wen/host_idx/host_wdat : user-side write port (ignores WR_MASK)
//   reg_o                       : packed register contents, index i at [16*i+:16]
//   reg_update/reg_update_any   : per-register stretched update flags and their OR
module modbus_holding_reg_bank
  import modbus_pkg::*;
#(
  parameter int                        REG_NUM     = 8,
  parameter logic [15:0]               REG_BASE    = 16'h0000,
  parameter int                        INTR_CLOCK  = 5,
  parameter logic [REG_W*REG_NUM-1:0]  REG_RST_VAL = '0,
  parameter logic [REG_NUM-1:0]        WR_MASK     = '1,
  localparam int                       IDX_W       = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reg_wen,
  input  logic [15:0]                reg_waddr,
  input  logic [REG_W-1:0]           reg_wdat,
  output logic                       reg_w_done,
  output logic [1:0]                 reg_w_status,
  input  logic                       rd_en,
  input  logic [15:0]                rd_addr,
  output logic [REG_W-1:0]           rd_data,
  output logic                       rd_vld,
  output logic                       rd_err,
  input  logic                       host_wen,
  input  logic [IDX_W-1:0]           host_idx,
  input  logic [REG_W-1:0]           host_wdat,
  output logic [REG_W*REG_NUM-1:0]   reg_o,
  output logic [REG_NUM-1:0]         reg_update,
  output logic                       reg_update_any
);

  logic [REG_W-1:0] regs [REG_NUM];

  // Address decode. The offset is taken modulo 2^16, so the explicit
  // lower-bound compare rejects addresses below REG_BASE.
  logic [15:0]      w_off, r_off;
  logic             w_in, r_in, host_ok;
  logic [IDX_W-1:0] widx, ridx;

  assign w_off   = reg_waddr - REG_BASE;
  assign r_off   = rd_addr - REG_BASE;
  assign w_in    = (reg_waddr >= REG_BASE) && (w_off < 16'(REG_NUM));
  assign r_in    = (rd_addr >= REG_BASE) && (r_off < 16'(REG_NUM));
  assign widx    = w_off[IDX_W-1:0];
  assign ridx    = r_off[IDX_W-1:0];
  assign host_ok = host_wen && (32'(host_idx) < 32'(REG_NUM));

  wr_status_e       w_status;
  logic             w_ok;
  logic [REG_NUM-1:0] upd_load;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_status = WST_OK;
    upd_load = '0;
    if (!w_in)                                w_status = WST_ILL_ADDR;
    else if (!WR_MASK[widx])                  w_status = WST_RO;
    else if (host_ok && (host_idx == widx))   w_status = WST_CONFLICT;
    if (reg_wen && (w_status == WST_OK))      upd_load[widx] = 1'b1;
  end

  assign w_ok = reg_wen && (w_status == WST_OK);

  // NOTE: the bank is a handful of flops with individual reset values, so it
  // is reset explicitly; a RAM-style array would be left unreset instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= REG_RST_VAL[REG_W*i +: REG_W];
      reg_w_done   <= 1'b0;
      reg_w_status <= WST_OK;
      rd_vld       <= 1'b0;
      rd_err       <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (w_ok)    regs[widx]     <= reg_wdat;
      // Host write is last so it wins on a same-index collision.
      if (host_ok) regs[host_idx] <= host_wdat;

      reg_w_done <= reg_wen;
      if (reg_wen) reg_w_status <= w_status;

      // Reads see pre-edge contents: read-before-write.
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_data <= r_in ? regs[ridx] : '0;
        rd_err  <= !r_in;
      end
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
    assign reg_o[REG_W*g +: REG_W] = regs[g];

    modbus_update_stretch #(
      .INTR_CLOCK (INTR_CLOCK)
    ) u_stretch (
      .clk  (clk),
      .rst  (rst),
      .load (upd_load[g]),
      .flag (reg_update[g])
    );
  end

  assign reg_update_any = |reg_update;

endmodule
